sync_fifo_ram: RTL and testbench

//  Parametrised single-clock FIFO with its own inferred dual-port storage array.

---
 rtl/sync_fifo_ram_if.sv | 34 +++
 rtl/sync_fifo_ram.sv | 147 ++++++++++++++
 tb/tb_sync_fifo_ram.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_ram_if.sv
// Handshake/bus bundle for sync_fifo_ram: producer/consumer requests in,
// registered read data and status flags out.
interface sync_fifo_ram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
);
  logic                  clear;
  logic                  write_enable;
  logic [DATA_WIDTH-1:0] data;
  logic                  read_enable;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  // Side that issues requests and observes the buffer
  modport master (
    output clear, write_enable, data, read_enable,
    input  out_data, out_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  // The buffer itself
  modport slave (
    input  clear, write_enable, data, read_enable,
    output out_data, out_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ram.sv
// Single-clock FIFO with its own inferred dual-port storage array.
// Occupancy count drives registered full/empty/watermark flags; overflow and
// underflow are sticky until reset or clear. Read data has one clock latency.
module sync_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int AF_MARGIN  = 4,
  parameter int AE_MARGIN  = 4
) (
  input logic           clk,
  input logic           rst_n,
  sync_fifo_ram_if.slave bus
);

  localparam int                  DEPTH      = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C    = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LEVEL_C = (ADDR_WIDTH + 1)'(DEPTH - AF_MARGIN);
  localparam logic [ADDR_WIDTH:0] AE_LEVEL_C = (ADDR_WIDTH + 1)'(AE_MARGIN);
  localparam logic [ADDR_WIDTH:0] ONE_C      = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE_C = ADDR_WIDTH'(1);

  // Storage: intentionally not reset so it maps onto plain RAM
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  out_valid_q, out_valid_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  almost_full_q, almost_full_d;
  logic                  almost_empty_q, almost_empty_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc_s;
  logic                  rd_acc_s;

  // Next-state: clear wins; otherwise accept on pre-edge flags, flags follow new count
  always_comb begin
    wr_acc_s       = 1'b0;
    rd_acc_s       = 1'b0;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    out_d          = out_q;
    out_valid_d    = 1'b0;
    full_d         = full_q;
    empty_d        = empty_q;
    almost_full_d  = almost_full_q;
    almost_empty_d = almost_empty_q;
    overflow_d     = overflow_q;
    underflow_d    = underflow_q;

    if (bus.clear) begin
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      count_d        = '0;
      out_d          = '0;
      out_valid_d    = 1'b0;
      full_d         = 1'b0;
      empty_d        = 1'b1;
      almost_full_d  = 1'b0;
      almost_empty_d = 1'b1;
      overflow_d     = 1'b0;
      underflow_d    = 1'b0;
    end else begin
      wr_acc_s = bus.write_enable && !full_q;
      rd_acc_s = bus.read_enable && !empty_q;

      if (wr_acc_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE_C;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (rd_acc_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE_C;
        out_d    = mem_q[rd_ptr_q];
      end else begin
        rd_ptr_d = rd_ptr_q;
        out_d    = out_q;
      end
      out_valid_d = rd_acc_s;

      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase

      overflow_d     = overflow_q  | (bus.write_enable & full_q);
      underflow_d    = underflow_q | (bus.read_enable & empty_q);
      full_d         = (count_d == DEPTH_C);
      empty_d        = (count_d == '0);
      almost_full_d  = (count_d >= AF_LEVEL_C);
      almost_empty_d = (count_d <= AE_LEVEL_C);
    end
  end

  // Control/status registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      out_q          <= '0;
      out_valid_q    <= 1'b0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      out_q          <= out_d;
      out_valid_q    <= out_valid_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  // Storage write port; a clear cycle never writes
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_q[wr_ptr_q] <= bus.data;
    end
  end

  assign bus.out_data     = out_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ram.sv
// Randomised scoreboard bench for sync_fifo_ram: a queue-based reference
// model predicts read data and flags; a separate monitor checks read data.
`timescale 1ns/1ps
module tb_sync_fifo_ram;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int AFM   = 4;
  localparam int AEM   = 4;

  logic clk;
  logic rst_n;

  sync_fifo_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sync_fifo_ram #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_MARGIN(AFM), .AE_MARGIN(AEM)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [DW-1:0] model_q[$];   // words held by the FIFO, oldest first
  logic [DW-1:0] exp_q[$];     // read data expected on Out, in order
  logic [DW-1:0] exp_hold;     // value Out must hold when no read occurs
  bit            m_ovf, m_unf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_flags(input bit exp_valid);
    int cnt;
    cnt = model_q.size();
    chk("count",        32'(bus.count),        32'(cnt));
    chk("full",         32'(bus.full),         32'(cnt == DEPTH));
    chk("empty",        32'(bus.empty),        32'(cnt == 0));
    chk("almost_full",  32'(bus.almost_full),  32'(cnt >= DEPTH - AFM));
    chk("almost_empty", 32'(bus.almost_empty), 32'(cnt <= AEM));
    chk("overflow",     32'(bus.overflow),     32'(m_ovf));
    chk("underflow",    32'(bus.underflow),    32'(m_unf));
    chk("out_valid",    32'(bus.out_valid),    32'(exp_valid));
  endtask

  // One clock of stimulus; model evaluated on pre-edge state
  task automatic step(input bit we, input bit re, input logic [DW-1:0] d, input bit clr);
    int cnt;
    bit racc;
    racc = 1'b0;
    bus.write_enable = we;
    bus.read_enable  = re;
    bus.data         = d;
    bus.clear        = clr;
    cnt = model_q.size();
    if (clr) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (we && cnt == DEPTH) m_ovf = 1'b1;
      if (re && cnt == 0)     m_unf = 1'b1;
      if (re && cnt > 0) begin
        racc = 1'b1;
        exp_q.push_back(model_q.pop_front());
      end
      if (we && cnt < DEPTH) model_q.push_back(d);
    end
    @(posedge clk);
    #1;
    if (clr) exp_hold = '0;
    check_flags(racc);
  endtask

  // Asynchronous reset pulse between clock edges
  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    model_q.delete();
    exp_q.delete();
    exp_hold = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #1;
    check_flags(1'b0);
    chk("out_after_reset", 32'(bus.out_data), 32'h0);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: compare read data against scoreboard, and hold value otherwise
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.out_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL out_unexpected: got %0h expected no read", bus.out_data);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", 32'(bus.out_data), 32'(e));
            exp_hold = e;
          end
        end else begin
          chk("out_hold", 32'(bus.out_data), 32'(exp_hold));
        end
      end
    end
  end

  initial begin
    bus.clear        = 1'b0;
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    bus.data         = '0;
    exp_hold         = '0;
    m_ovf            = 1'b0;
    m_unf            = 1'b0;
    rst_n            = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_flags(1'b0);
    chk("out_reset", 32'(bus.out_data), 32'h0);
    rst_n = 1'b1;

    // Fill with 0x01..0x20
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, DW'(i), 1'b0);
    // Write while full is dropped
    step(1'b1, 1'b0, 8'hAA, 1'b0);
    // Full with both requests: only the read happens
    step(1'b1, 1'b1, 8'hBB, 1'b0);
    // Drain
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    // Read while empty, then clear
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Fill to 5 then stream with simultaneous read/write, pointers wrap
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(8'h40 + i), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, DW'(8'h50 + i), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

    // Write 3 words, asynchronous reset, then fresh write/read
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(8'hC0 + i), 1'b0);
    pulse_reset();
    step(1'b1, 1'b0, 8'h5A, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Randomised traffic with occasional clear
    for (int i = 0; i < 600; i++) begin
      bit we, re, clr;
      int bias;
      bias = (i / 100) % 3;
      we  = ($urandom_range(0, 9) < (bias == 0 ? 7 : (bias == 1 ? 3 : 5)));
      re  = ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 7 : 5)));
      clr = ($urandom_range(0, 63) == 0);
      step(we, re, DW'($urandom_range(0, 255)), clr);
    end

    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
